hazard_scheduler: RTL and testbench
===================================

Name: hazard_scheduler

Overview:
- Pipeline hazard and stall scheduler for the 5-stage pipelined processor (F, D, E, M, W).
- Inputs come from the Decode/Execute/Memory/Writeback register tags and control bits.
- Drives the operand-forwarding selects, the per-stage stall/flush enables, and a multi-cycle data-memory wait sequencer.
- Owns all pipeline sequencing so the stage modules hold no hazard logic.

Parameters:
- WAIT_STATES, 2, data-memory wait cycles per access in M (0..15; 0 = single-cycle memory, the FSM never leaves IDLE).
- CNT_W, 4, wait-counter width; must hold WAIT_STATES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- RA1D, RA2D  input  4 each  source register tags in Decode.
- RA1E, RA2E  input  4 each  source register tags in Execute.
- WA3E, WA3M, WA3W  input  4 each  destination tags in E/M/W.
- RegWriteM, RegWriteW  input  1 each  register write enables in M/W.
- MemtoRegE  input  1  load instruction in Execute.
- BranchTakenE  input  1  branch resolved taken in Execute.
- MemReqM  input  1  memory access (load or store) in M.
- ForwardAE, ForwardBE  output  2 each  operand select: 00 = register file, 01 = ResultW, 10 = ALUResultM.
- StallF, StallD, StallE, StallM  output  1 each  hold the stage register.
- FlushD, FlushE, FlushW  output  1 each  insert a bubble in that stage register.
- MemBusy  output  1  wait sequence in progress.

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0. Outputs while reset is low: Forward*=00, all Stall*=0, FlushD=FlushE=1, FlushW=0, MemBusy=0.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM & WA3M==RA1E.
  - else ForwardAE=01 if RegWriteW & WA3W==RA1E.
  - else ForwardAE=00.
  - M has priority over W. Same rules for ForwardBE with RA2E. Tag 15 is forwarded like any other.
- Load-use: LdStall = MemtoRegE & (WA3E==RA1D | WA3E==RA2D).
- FSM states are IDLE, WAIT, RELEASE.
- IDLE:
  - If MemReqM & WAIT_STATES>0: assert StallF/D/E/M and FlushW in the same cycle, load counter=WAIT_STATES-1, go to WAIT if the counter is nonzero, else RELEASE.
  - Otherwise normal hazard outputs:
    - StallF=StallD=LdStall.
    - FlushE=LdStall | BranchTakenE.
    - FlushD=BranchTakenE.
- WAIT:
  - StallF/D/E/M=1, FlushW=1, MemBusy=1. FlushD=FlushE=0.
  - BranchTakenE and LdStall are ignored; the instruction is held in E and re-evaluated after release.
  - Counter decrements; at counter==0 go to RELEASE.
- RELEASE:
  - No memory stall, so the M instruction advances exactly once. Normal load-use/branch outputs apply. MemBusy=0.
  - Next state is IDLE unconditionally. The MemReqM seen this cycle belongs to the same instruction and must not retrigger.
- Total memory stall per access is exactly WAIT_STATES cycles. Back-to-back accesses each get the full wait (RELEASE, then IDLE re-detects).
- Stall and flush interaction: when StallE=1, FlushE=0 (stall dominates). When StallD=1 and BranchTakenE=1 outside WAIT, the flush wins for D (FlushD=1, StallD=0); F still loads the branch target (StallF=0).
- Reset asserted mid-WAIT: immediate return to IDLE, counter cleared, reset outputs.

Optional Feature:
- HAZARD_PERF_EN defined:
  - Adds output ports StallCount[15:0] and FlushCount[15:0].
  - Both are saturating counters, reset to 0.
  - StallCount increments on every cycle with StallD=1.
  - FlushCount increments on every cycle with FlushE=1 while reset is high.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with MemReqM=1 -> Forward*=00, Stall*=0, FlushD=FlushE=1, MemBusy=0; release -> IDLE.
- Forwarding:
  - RegWriteM=1, WA3M=3, RA1E=3, RegWriteW=1, WA3W=3 -> ForwardAE=10.
  - Drop RegWriteM -> ForwardAE=01.
  - RA2E=4 with no match -> ForwardBE=00.
- Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=1 and FlushE=1 for 1 cycle; next cycle with MemtoRegE=0 -> all 0.
- Memory wait, WAIT_STATES=2, MemReqM=1 held -> StallF/D/E/M=1 for exactly 2 cycles, then 1 RELEASE cycle with stalls 0, then no retrigger unless MemReqM is held into a new IDLE cycle.
- Branch during wait: BranchTakenE=1 throughout the 2-cycle wait -> FlushD=FlushE=0 during WAIT; FlushD=FlushE=1 in the RELEASE cycle.
- Reset mid-wait: reset=0 in the 2nd WAIT cycle -> MemBusy=0 immediately; after release, MemReqM=1 -> a fresh 2-cycle wait.

Source files
------------

// File: rtl/hazard_scheduler_if.sv
// Hazard-scheduler bus: pipeline register tags/controls in, forwarding/stall/flush controls out.
interface hazard_scheduler_if;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned FWD_W = 2;

   logic [TAG_W-1:0] ra1d;
   logic [TAG_W-1:0] ra2d;
   logic [TAG_W-1:0] ra1e;
   logic [TAG_W-1:0] ra2e;
   logic [TAG_W-1:0] wa3e;
   logic [TAG_W-1:0] wa3m;
   logic [TAG_W-1:0] wa3w;
   logic             regwritem;
   logic             regwritew;
   logic             memtorege;
   logic             branchtakene;
   logic             memreqm;

   logic [FWD_W-1:0] forwardae;
   logic [FWD_W-1:0] forwardbe;
   logic             stallf;
   logic             stalld;
   logic             stalle;
   logic             stallm;
   logic             flushd;
   logic             flushe;
   logic             flushw;
   logic             membusy;

   modport master (
      output ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
      output regwritem, regwritew, memtorege, branchtakene, memreqm,
      input  forwardae, forwardbe,
      input  stallf, stalld, stalle, stallm,
      input  flushd, flushe, flushw, membusy
   );

   modport slave (
      input  ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w,
      input  regwritem, regwritew, memtorege, branchtakene, memreqm,
      output forwardae, forwardbe,
      output stallf, stalld, stalle, stallm,
      output flushd, flushe, flushw, membusy
   );
endinterface

// File: rtl/hazard_scheduler.sv
// Pipeline hazard/stall scheduler: operand forwarding, load-use and branch handling, memory wait FSM.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_scheduler #(
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned CNT_W       = 4
) (
   input  logic               clk,
   input  logic               reset,
   hazard_scheduler_if.slave  hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0]        stall_count,
   output logic [15:0]        flush_count
`endif
);

   localparam int unsigned TAG_W  = 4;
   localparam int unsigned FWD_W  = 2;
   localparam int unsigned PERF_W = 16;

   localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
   localparam logic [FWD_W-1:0] FWD_W_S = 2'b01;
   localparam logic [FWD_W-1:0] FWD_M_S = 2'b10;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   localparam bit MEM_WAIT_EN = (WAIT_STATES != 0);
   localparam logic [CNT_W-1:0] LOAD_VAL =
      MEM_WAIT_EN ? CNT_W'(WAIT_STATES - 1) : '0;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ldstall;
   logic             mem_hold;

   // M stage result is newer than W, so it wins when both match.
   function automatic logic [FWD_W-1:0] fwd_sel(
      input logic [TAG_W-1:0] ra,
      input logic [TAG_W-1:0] wam,
      input logic             wem,
      input logic [TAG_W-1:0] waw,
      input logic             wew
   );
      logic [FWD_W-1:0] sel;
      sel = FWD_RF;
      if (wem && (wam == ra)) begin
         sel = FWD_M_S;
      end else if (wew && (waw == ra)) begin
         sel = FWD_W_S;
      end
      return sel;
   endfunction

   always_comb begin
      hz.forwardae = FWD_RF;
      hz.forwardbe = FWD_RF;
      if (reset) begin
         hz.forwardae = fwd_sel(hz.ra1e, hz.wa3m, hz.regwritem, hz.wa3w, hz.regwritew);
         hz.forwardbe = fwd_sel(hz.ra2e, hz.wa3m, hz.regwritem, hz.wa3w, hz.regwritew);
      end
   end

   assign ldstall = hz.memtorege && ((hz.wa3e == hz.ra1d) || (hz.wa3e == hz.ra2d));

   // State and wait counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state plus stall/flush outputs; the trigger cycle already counts as a wait cycle.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      mem_hold   = 1'b0;
      hz.stallf  = 1'b0;
      hz.stalld  = 1'b0;
      hz.stalle  = 1'b0;
      hz.stallm  = 1'b0;
      hz.flushd  = 1'b0;
      hz.flushe  = 1'b0;
      hz.flushw  = 1'b0;
      hz.membusy = 1'b0;

      case (state)
         S_IDLE: begin
            if (hz.memreqm && MEM_WAIT_EN) begin
               mem_hold  = 1'b1;
               cnt_nxt   = LOAD_VAL;
               state_nxt = (LOAD_VAL != '0) ? S_WAIT : S_RELEASE;
            end
         end
         S_WAIT: begin
            mem_hold   = 1'b1;
            hz.membusy = 1'b1;
            if (cnt <= CNT_W'(1)) begin
               cnt_nxt   = '0;
               state_nxt = S_RELEASE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_RELEASE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase

      if (mem_hold) begin
         hz.stallf = 1'b1;
         hz.stalld = 1'b1;
         hz.stalle = 1'b1;
         hz.stallm = 1'b1;
         hz.flushw = 1'b1;
      end else begin
         // A taken branch squashes D, so the load-use hold is dropped in favour of the target fetch.
         hz.stallf = ldstall && !hz.branchtakene;
         hz.stalld = ldstall && !hz.branchtakene;
         hz.flushd = hz.branchtakene;
         hz.flushe = ldstall || hz.branchtakene;
      end

      if (!reset) begin
         hz.stallf  = 1'b0;
         hz.stalld  = 1'b0;
         hz.stalle  = 1'b0;
         hz.stallm  = 1'b0;
         hz.flushd  = 1'b1;
         hz.flushe  = 1'b1;
         hz.flushw  = 1'b0;
         hz.membusy = 1'b0;
      end
   end

`ifdef HAZARD_PERF_EN
   // Saturating event counters; held at zero while reset is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (hz.stalld && (stall_count != {PERF_W{1'b1}})) begin
            stall_count <= stall_count + PERF_W'(1);
         end
         if (hz.flushe && (flush_count != {PERF_W{1'b1}})) begin
            flush_count <= flush_count + PERF_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed self-checking bench for hazard_scheduler (WAIT_STATES=2).
module tb_hazard_scheduler;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   // Control bundle: {stallf, stalld, stalle, stallm, flushd, flushe, flushw, membusy}.
   localparam logic [7:0] C_IDLE = 8'b0000_0000;
   localparam logic [7:0] C_RST  = 8'b0000_1100;
   localparam logic [7:0] C_LDU  = 8'b1100_0100;
   localparam logic [7:0] C_BR   = 8'b0000_1100;
   localparam logic [7:0] C_WAIT = 8'b1111_0011;

   hazard_scheduler_if hz ();

`ifdef HAZARD_PERF_EN
   logic [15:0] stall_count;
   logic [15:0] flush_count;
`endif

   hazard_scheduler #(
      .WAIT_STATES (2),
      .CNT_W       (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .hz          (hz.slave)
`ifdef HAZARD_PERF_EN
      ,
      .stall_count (stall_count),
      .flush_count (flush_count)
`endif
   );

   logic [7:0] ctl;
   assign ctl = {hz.stallf, hz.stalld, hz.stalle, hz.stallm,
                 hz.flushd, hz.flushe, hz.flushw, hz.membusy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      reset           = 1'b0;
      hz.ra1d         = 4'd0;
      hz.ra2d         = 4'd0;
      hz.ra1e         = 4'd3;
      hz.ra2e         = 4'd4;
      hz.wa3e         = 4'd0;
      hz.wa3m         = 4'd3;
      hz.wa3w         = 4'd3;
      hz.regwritem    = 1'b1;
      hz.regwritew    = 1'b1;
      hz.memtorege    = 1'b0;
      hz.branchtakene = 1'b0;
      hz.memreqm      = 1'b1;

      // Reset held with a pending memory request and forwarding matches.
      repeat (2) tick();
      check("rst_fa", 8'(hz.forwardae), 8'h00);
      check("rst_fb", 8'(hz.forwardbe), 8'h00);
      check("rst_ctl", ctl, C_RST);

      hz.memreqm = 1'b0;
      reset      = 1'b1;
      settle();
      check("post_rst_ctl", ctl, C_IDLE);
      check("fwd_m", 8'(hz.forwardae), 8'h02);
      check("fwd_nomatch", 8'(hz.forwardbe), 8'h00);

      tick();
      hz.regwritem = 1'b0;
      settle();
      check("fwd_w", 8'(hz.forwardae), 8'h01);

      tick();
      hz.regwritem = 1'b1;
      hz.wa3m      = 4'd15;
      hz.ra2e      = 4'd15;
      settle();
      check("fwd_tag15_b", 8'(hz.forwardbe), 8'h02);
      check("fwd_w_a", 8'(hz.forwardae), 8'h01);

      tick();
      hz.regwritem = 1'b0;
      hz.regwritew = 1'b0;
      hz.wa3w      = 4'd15;
      settle();
      check("fwd_no_we", 8'(hz.forwardbe), 8'h00);

      // Load-use on RA2D, then clear.
      tick();
      hz.memtorege = 1'b1;
      hz.wa3e      = 4'd5;
      hz.ra2d      = 4'd5;
      settle();
      check("ldu_ra2", ctl, C_LDU);
      tick();
      hz.memtorege = 1'b0;
      settle();
      check("ldu_clear", ctl, C_IDLE);
      tick();
      hz.memtorege = 1'b1;
      hz.ra1d      = 4'd5;
      hz.ra2d      = 4'd1;
      settle();
      check("ldu_ra1", ctl, C_LDU);
      tick();
      hz.branchtakene = 1'b1;
      settle();
      check("ldu_branch", ctl, C_BR);
      tick();
      hz.memtorege = 1'b0;
      settle();
      check("branch_only", ctl, C_BR);
      tick();
      hz.branchtakene = 1'b0;
      hz.ra1d         = 4'd0;
      settle();
      check("idle_again", ctl, C_IDLE);

      // Memory wait with request held through release.
      tick();
      hz.memreqm = 1'b1;
      settle();
      check("mw_trig", ctl | 8'h01, C_WAIT);
      tick();
      settle();
      check("mw_wait", ctl, C_WAIT);
      tick();
      settle();
      check("mw_release", ctl, C_IDLE);
      tick();
      settle();
      check("mw_retrig", ctl | 8'h01, C_WAIT);
      tick();
      settle();
      check("mw_wait2", ctl, C_WAIT);
      tick();
      settle();
      check("mw_release2", ctl, C_IDLE);
      tick();
      hz.memreqm = 1'b0;
      settle();
      check("mw_no_retrig", ctl, C_IDLE);

      // Branch held through a wait: ignored until release.
      tick();
      hz.memreqm      = 1'b1;
      hz.branchtakene = 1'b1;
      settle();
      check("br_trig", ctl | 8'h01, C_WAIT);
      tick();
      settle();
      check("br_wait", ctl, C_WAIT);
      tick();
      settle();
      check("br_release", ctl, C_BR);
      tick();
      hz.memreqm      = 1'b0;
      hz.branchtakene = 1'b0;
      settle();
      check("br_idle", ctl, C_IDLE);

      // Reset asserted in the WAIT cycle, then a fresh full wait.
      tick();
      hz.memreqm = 1'b1;
      settle();
      check("rw_trig", ctl | 8'h01, C_WAIT);
      tick();
      settle();
      check("rw_wait", ctl, C_WAIT);
      reset = 1'b0;
      settle();
      check("rw_reset_ctl", ctl, C_RST);
      tick();
      hz.memreqm = 1'b0;
      reset      = 1'b1;
      settle();
      check("rw_idle", ctl, C_IDLE);
      tick();
      hz.memreqm = 1'b1;
      settle();
      check("rw_fresh_trig", ctl | 8'h01, C_WAIT);
      tick();
      settle();
      check("rw_fresh_wait", ctl, C_WAIT);
      tick();
      settle();
      check("rw_fresh_release", ctl, C_IDLE);
      tick();
      hz.memreqm = 1'b0;
      settle();
      check("rw_end_idle", ctl, C_IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
